lane_dly_move_seq: RTL

//  Sequencer for the per-lane DDR4 PHY delay line. It sits directly upstream of the lane

---
 rtl/lane_dly_pkg.sv | 28 ++
 rtl/lane_dly_move_seq_if.sv | 49 ++++
 rtl/lane_dly_wait_cnt.sv | 30 +++
 rtl/lane_dly_move_seq.sv | 137 +++++++++++++
 4 files changed

// File: rtl/lane_dly_pkg.sv
// Shared types and default timing for the lane delay-line move sequencer.
// The LANE_DLY_LOAD_EN macro (see lane_dly_move_seq.sv) makes the LOAD state reachable.
package lane_dly_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PAUSE,
        LOAD,
        MOVE,
        GAP,
        UNPAUSE,
        DONE
    } state_t;

    localparam int STEP_W_DEF      = 8;
    localparam int PAUSE_SETUP_DEF = 4;
    localparam int MOVE_GAP_DEF    = 3;
    localparam int PAUSE_HOLD_DEF  = 4;

    // Width of the shared wait counter; every timing parameter must fit in it.
    localparam int CNT_W = 8;

    // A wait of N cycles loads N-1: the counter reaches zero on the Nth cycle.
    function automatic logic [CNT_W-1:0] wait_val(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/lane_dly_move_seq_if.sv
// Request handshake plus lane-controller delay-line signals of the move sequencer.
// REQ_LOAD exists only when LANE_DLY_LOAD_EN is defined.
interface lane_dly_move_seq_if #(
    parameter int STEP_W = 8
);
    logic              REQ_VALID;
    logic              REQ_READY;
    logic              REQ_SEL;
    logic              REQ_DIR;
    logic [STEP_W-1:0] REQ_STEPS;
`ifdef LANE_DLY_LOAD_EN
    logic              REQ_LOAD;
`endif
    logic              DONE;
    logic              ERR_OOR;
    logic [STEP_W-1:0] STEPS_DONE;
    logic              RX_DELAY_LINE_OUT_OF_RANGE;
    logic              TX_DELAY_LINE_OUT_OF_RANGE;
    logic              DELAY_LINE_SEL;
    logic              DELAY_LINE_DIRECTION;
    logic              DELAY_LINE_MOVE;
    logic              DELAY_LINE_LOAD;
    logic              HS_IO_CLK_PAUSE;

    // Sequencer side.
    modport slave (
        input  REQ_VALID, REQ_SEL, REQ_DIR, REQ_STEPS,
`ifdef LANE_DLY_LOAD_EN
        input  REQ_LOAD,
`endif
        input  RX_DELAY_LINE_OUT_OF_RANGE, TX_DELAY_LINE_OUT_OF_RANGE,
        output REQ_READY, DONE, ERR_OOR, STEPS_DONE,
        output DELAY_LINE_SEL, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE,
        output DELAY_LINE_LOAD, HS_IO_CLK_PAUSE
    );

    // Training logic / lane controller side.
    modport master (
        output REQ_VALID, REQ_SEL, REQ_DIR, REQ_STEPS,
`ifdef LANE_DLY_LOAD_EN
        output REQ_LOAD,
`endif
        output RX_DELAY_LINE_OUT_OF_RANGE, TX_DELAY_LINE_OUT_OF_RANGE,
        input  REQ_READY, DONE, ERR_OOR, STEPS_DONE,
        input  DELAY_LINE_SEL, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE,
        input  DELAY_LINE_LOAD, HS_IO_CLK_PAUSE
    );

endinterface

// File: rtl/lane_dly_wait_cnt.sv
// Loadable down-counter with zero flag, shared by the PAUSE, GAP and UNPAUSE waits.
module lane_dly_wait_cnt
    import lane_dly_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         FAB_CLK,
    input  logic         RESET,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // Count down to zero and stop there; a load restarts the wait.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/lane_dly_move_seq.sv
// Per-lane DDR4 PHY delay-line move sequencer: pauses the HS IO clock, issues N spaced
// MOVE pulses, aborts on the selected out-of-range flag, then unpauses and reports DONE.
// Optional: define LANE_DLY_LOAD_EN to add REQ_LOAD and a LOAD pulse after PAUSE.
module lane_dly_move_seq
    import lane_dly_pkg::*;
#(
    parameter int STEP_W      = STEP_W_DEF,
    parameter int PAUSE_SETUP = PAUSE_SETUP_DEF,
    parameter int MOVE_GAP    = MOVE_GAP_DEF,
    parameter int PAUSE_HOLD  = PAUSE_HOLD_DEF
) (
    input  logic                FAB_CLK,
    input  logic                RESET,
    lane_dly_move_seq_if.slave  bus
);

    state_t            state, state_nxt;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_val;
    logic              cnt_zero;
    logic              sel_q, dir_q, err_q, load_q, req_load, oor_sel;
    logic [STEP_W-1:0] rem_q, steps_done_q;

`ifdef LANE_DLY_LOAD_EN
    assign req_load = bus.REQ_LOAD;

    // Remember whether this request asked for a LOAD before moving.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            load_q <= 1'b0;
        end else if (state == IDLE && bus.REQ_VALID) begin
            load_q <= bus.REQ_LOAD;
        end
    end

    assign bus.DELAY_LINE_LOAD = (state == LOAD);
`else
    assign req_load            = 1'b0;
    assign load_q              = 1'b0;
    assign bus.DELAY_LINE_LOAD = 1'b0;
`endif

    assign oor_sel = sel_q ? bus.TX_DELAY_LINE_OUT_OF_RANGE
                           : bus.RX_DELAY_LINE_OUT_OF_RANGE;

    lane_dly_wait_cnt #(.W(CNT_W)) u_wait (
        .FAB_CLK  (FAB_CLK),
        .RESET    (RESET),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and wait-counter reloads.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        case (state)
            IDLE: begin
                if (bus.REQ_VALID) begin
                    if (bus.REQ_STEPS == '0 && !req_load) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = PAUSE;
                        cnt_load  = 1'b1;
                        cnt_val   = wait_val(PAUSE_SETUP);
                    end
                end
            end
            PAUSE: begin
                if (cnt_zero) state_nxt = load_q ? LOAD : MOVE;
            end
            LOAD, MOVE: begin
                state_nxt = GAP;
                cnt_load  = 1'b1;
                cnt_val   = wait_val(MOVE_GAP);
            end
            GAP: begin
                if (cnt_zero) begin
                    if (oor_sel || rem_q == '0) begin
                        state_nxt = UNPAUSE;
                        cnt_load  = 1'b1;
                        cnt_val   = wait_val(PAUSE_HOLD);
                    end else begin
                        state_nxt = MOVE;
                    end
                end
            end
            UNPAUSE: begin
                if (cnt_zero) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, remaining/issued move counts and the sticky out-of-range error.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            sel_q        <= 1'b0;
            dir_q        <= 1'b0;
            err_q        <= 1'b0;
            rem_q        <= '0;
            steps_done_q <= '0;
        end else if (state == IDLE && bus.REQ_VALID) begin
            sel_q        <= bus.REQ_SEL;
            dir_q        <= bus.REQ_DIR;
            err_q        <= 1'b0;
            rem_q        <= bus.REQ_STEPS;
            steps_done_q <= '0;
        end else begin
            if (state == MOVE) begin
                rem_q <= rem_q - 1'b1;
                if (steps_done_q != '1) steps_done_q <= steps_done_q + 1'b1;
            end
            if (state == GAP && cnt_zero && oor_sel) err_q <= 1'b1;
        end
    end

    assign bus.REQ_READY            = (state == IDLE);
    assign bus.HS_IO_CLK_PAUSE      = (state inside {PAUSE, LOAD, MOVE, GAP});
    assign bus.DELAY_LINE_MOVE      = (state == MOVE);
    assign bus.DELAY_LINE_SEL       = (state != IDLE) && sel_q;
    assign bus.DELAY_LINE_DIRECTION = (state != IDLE) && dir_q;
    assign bus.DONE                 = (state == DONE);
    assign bus.ERR_OOR              = (state == DONE) && err_q;
    assign bus.STEPS_DONE           = steps_done_q;

endmodule
